// File: rtl/if_pkg.sv
// Shared defaults for the instruction-fetch stage: address/instruction widths,
// reset vector and the layout of one fetched entry.
package if_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;

  localparam logic [AW_DEF-1:0] RESET_VEC = '0;

  typedef struct packed {
    logic [IW_DEF-1:0] data;
    logic [AW_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO of fetch entries. The head entry is read straight
// from storage registers; flush has priority over push and pop.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          valid,
  output entry_t        head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: next-PC selection, ROM issue, in-flight tracking and
// prefetch buffering toward decode. Optional counters under IF_PERF_EN.
module if_fetch
  import if_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_c,
  output logic [AW-1:0] addr_n,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  output logic          inst_valid,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
`ifdef IF_PERF_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_flushed
`endif
);

  typedef struct packed {
    logic [IW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  localparam int CW = $clog2(DEPTH + 1);

  logic          pop;
  logic          push;
  logic          issue;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic          fifo_full;
  logic          fifo_valid;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  entry_t        head;
  entry_t        din;

  // Decode handshake: a word transfers on any cycle where inst_valid and
  // inst_ready are both high; inst_valid never depends on inst_ready and the
  // presented word stays unchanged until it is taken or flushed.
  assign pop = fifo_valid & inst_ready;

  // Buffered plus in-flight words after this cycle's pop must leave room.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = !br_valid && (occ < (CW+1)'(DEPTH));

  assign imem_addr = addr_c;

  always_comb begin
    addr_n = addr_c;
    if (br_valid)   addr_n = br_target;
    else if (issue) addr_n = addr_c + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= AW'(RESET_VEC);
    end else begin
      inflight    <= issue;
      inflight_pc <= addr_c;
    end
  end

  assign push = inflight && !br_valid && (!fifo_full || pop);
  assign din  = {imem_rdata, inflight_pc};

  if_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .flush (br_valid),
    .full  (fifo_full),
    .count (count),
    .valid (fifo_valid),
    .head  (head)
  );

  assign inst_valid = fifo_valid;
  assign inst_data  = fifo_valid ? head.data : '0;
  assign inst_pc    = fifo_valid ? head.pc   : '0;

`ifdef IF_PERF_EN
  logic [16:0] fetched_sum;
  logic [16:0] flushed_sum;

  assign fetched_sum = {1'b0, perf_fetched} + 17'd1;
  assign flushed_sum = {1'b0, perf_flushed} + 17'(count) + 17'(inflight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)     perf_fetched <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
      if (br_valid) perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: models the PC register and a 1-cycle ROM, runs a directed
// cycle table, an async-reset probe and a randomized stream against a program-order model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr_c;
  logic [7:0]  addr_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready;
`ifdef IF_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [256];

  typedef struct {
    logic        ready;
    logic        br;
    logic [7:0]  tgt;
    logic        v;
    logic [7:0]  pc;
    logic [15:0] data;
    logic [7:0]  an;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] exp_q[$];

  if_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_c     (addr_c),
    .addr_n     (addr_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef IF_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  // Clock, PC register and synchronous ROM around the stage.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_c <= 8'h00;
    else        addr_c <= addr_n;
  end

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input logic r, input logic b, input logic [7:0] t,
                         input logic v, input logic [7:0] pc, input logic [15:0] d,
                         input logic [7:0] an);
    vec_t e;
    e.ready = r; e.br = b; e.tgt = t; e.v = v; e.pc = pc; e.data = d; e.an = an;
    tbl.push_back(e);
  endtask

  logic [7:0]  exp_base;
  logic [23:0] exp_w;
  int          since_br;
  logic        prev_hold;
  logic [7:0]  prev_pc;
  logic [15:0] prev_data;

  initial begin
    // Directed cycle table: start-up, 5-cycle stall, redirect, redirect with pop, wrap.
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h01);
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h02);
    add_row(1, 0, 8'h00, 1, 8'h00, 16'hA000, 8'h03);
    add_row(1, 0, 8'h00, 1, 8'h01, 16'hA001, 8'h04);
    add_row(1, 0, 8'h00, 1, 8'h02, 16'hA002, 8'h05);
    for (int i = 0; i < 5; i++) add_row(0, 0, 8'h00, 1, 8'h03, 16'hA003, 8'h05);
    add_row(1, 0, 8'h00, 1, 8'h03, 16'hA003, 8'h06);
    add_row(1, 0, 8'h00, 1, 8'h04, 16'hA004, 8'h07);
    add_row(0, 1, 8'h40, 1, 8'h05, 16'hA005, 8'h40);
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h41);
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h42);
    add_row(1, 0, 8'h00, 1, 8'h40, 16'hA040, 8'h43);
    add_row(1, 0, 8'h00, 1, 8'h41, 16'hA041, 8'h44);
    add_row(1, 1, 8'hFE, 1, 8'h42, 16'hA042, 8'hFE);
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'hFF);
    add_row(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00);
    add_row(1, 0, 8'h00, 1, 8'hFE, 16'hA0FE, 8'h01);
    add_row(1, 0, 8'h00, 1, 8'hFF, 16'hA0FF, 8'h02);
    add_row(1, 0, 8'h00, 1, 8'h00, 16'hA000, 8'h03);
    add_row(1, 0, 8'h00, 1, 8'h01, 16'hA001, 8'h04);

    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);

    rst_n      = 1'b0;
    inst_ready = 1'b1;
    br_valid   = 1'b0;
    br_target  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_valid", inst_valid, 1'b0);
    check("reset_pc", inst_pc, 8'h00);
    check("reset_data", inst_data, 16'h0000);
`ifdef IF_PERF_EN
    check("reset_perf_fetched", perf_fetched, 16'h0000);
    check("reset_perf_flushed", perf_flushed, 16'h0000);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      inst_ready = tbl[i].ready;
      br_valid   = tbl[i].br;
      br_target  = tbl[i].tgt;
      #1;
      check($sformatf("row%0d_valid", i), inst_valid, tbl[i].v);
      check($sformatf("row%0d_pc", i), inst_pc, tbl[i].pc);
      check($sformatf("row%0d_data", i), inst_data, tbl[i].data);
      check($sformatf("row%0d_addr_n", i), addr_n, tbl[i].an);
      @(negedge clk);
    end
`ifdef IF_PERF_EN
    check("perf_fetched_after_table", perf_fetched, 16'd14);
    check("perf_flushed_after_table", perf_flushed, 16'd4);
`endif

    // Asynchronous reset in the middle of a live stream.
    check("pre_reset_valid", inst_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", inst_valid, 1'b0);
    check("async_reset_pc", inst_pc, 8'h00);
    check("async_reset_data", inst_data, 16'h0000);
`ifdef IF_PERF_EN
    check("async_reset_perf_fetched", perf_fetched, 16'h0000);
    check("async_reset_perf_flushed", perf_flushed, 16'h0000);
`endif

    // Randomized stream: accepted words must follow program order from the
    // last redirect target, with data equal to the ROM contents at that address.
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_base  = 8'h00;
    since_br  = 0;
    prev_hold = 1'b0;
    prev_pc   = 8'h00;
    prev_data = 16'h0000;
    rst_n     = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      br_valid   = ($urandom_range(0, 24) == 0);
      br_target  = 8'($urandom_range(0, 255));
      #1;
      if (prev_hold) begin
        check("hold_valid", inst_valid, 1'b1);
        check("hold_pc", inst_pc, prev_pc);
        check("hold_data", inst_data, prev_data);
      end
      if (!br_valid && since_br >= 2) check("stream_gap", inst_valid, 1'b1);
      if (br_valid) check("redirect_addr_n", addr_n, br_target);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          for (int j = 0; j < 4; j++) begin
            exp_q.push_back({rom[exp_base], exp_base});
            exp_base = exp_base + 8'd1;
          end
        end
        exp_w = exp_q.pop_front();
        check("accept_pc", inst_pc, exp_w[7:0]);
        check("accept_data", inst_data, exp_w[23:8]);
      end
      prev_hold = inst_valid && !inst_ready && !br_valid;
      prev_pc   = inst_pc;
      prev_data = inst_data;
      if (br_valid) begin
        exp_q.delete();
        exp_base = br_target;
        since_br = 0;
      end else if (since_br < 10) begin
        since_br++;
      end
      @(negedge clk);
    end

`ifdef IF_PERF_EN
    // Long free-running stream to reach counter saturation.
    rst_n = 1'b0;
    @(negedge clk);
    inst_ready = 1'b1;
    br_valid   = 1'b0;
    rst_n      = 1'b1;
    repeat (65600) @(negedge clk);
    check("perf_fetched_saturate", perf_fetched, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
